// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants and immediate format codes for the pipelined immediate generator.
package imm_gen_pipe_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FMT_W   = 3;

  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] SYSTEM    = 7'b1110011;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle; slave is the generator side.
interface imm_gen_pipe_if
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_imm;
  imm_fmt_t           out_fmt;
  logic [TAG_W-1:0]   out_tag;

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag
  );

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag
  );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RISC-V immediate decode (module imm_decode_comb).
// CSR-immediate (Z) decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_decode_comb
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [XLEN-1:0]    imm_c_o,
  output imm_fmt_t           fmt_c_o
);

  logic [31:0] u_imm;
  logic [12:0] b_imm;
  logic [20:0] j_imm;

  assign u_imm = {instr_i[31:12], 12'b0};
  assign b_imm = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign j_imm = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Signed size casts sign-extend from the top bit of each field.
  always_comb begin
    imm_c_o = '0;
    fmt_c_o = FMT_NONE;
    case (instr_i[6:0])
      OP_IMM, LOAD, JALR: begin
        imm_c_o = XLEN'($signed(instr_i[31:20]));
        fmt_c_o = FMT_I;
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          imm_c_o = XLEN'($signed(instr_i[31:20]));
          fmt_c_o = FMT_I;
        end
      end
      STORE: begin
        imm_c_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        fmt_c_o = FMT_S;
      end
      BRANCH: begin
        imm_c_o = XLEN'($signed(b_imm));
        fmt_c_o = FMT_B;
      end
      LUI, AUIPC: begin
        imm_c_o = XLEN'($signed(u_imm));
        fmt_c_o = FMT_U;
      end
      JAL: begin
        imm_c_o = XLEN'($signed(j_imm));
        fmt_c_o = FMT_J;
      end
`ifdef IMM_GEN_ZICSR_EN
      SYSTEM: begin
        if (instr_i[14]) begin
          imm_c_o = XLEN'(instr_i[19:15]);
          fmt_c_o = FMT_Z;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: input-side decode into a main/skid register pair.
// Optional CSR-immediate decode via IMM_GEN_ZICSR_EN (see imm_decode_comb).
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  imm;
    imm_fmt_t         fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          m_q, m_d;
  entry_t          k_q, k_d;
  entry_t          new_entry;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            accept;
  logic            fire;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr_i (bus.in_instr),
    .imm_c_o (dec_imm),
    .fmt_c_o (dec_fmt)
  );

  assign new_entry = '{valid: 1'b1, imm: dec_imm, fmt: dec_fmt, tag: bus.in_tag};
  assign accept    = bus.in_valid && !k_q.valid;
  assign fire      = m_q.valid && bus.out_ready;

  // Skid update: K only fills while M is held; M refills from K before new input.
  always_comb begin
    m_d = m_q;
    k_d = k_q;
    if (fire) begin
      if (k_q.valid) begin
        m_d       = k_q;
        k_d.valid = 1'b0;
      end else begin
        m_d.valid = 1'b0;
      end
    end
    if (accept) begin
      if (!m_q.valid || fire) begin
        m_d = new_entry;
      end else begin
        k_d = new_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      k_q <= '0;
    end else begin
      m_q <= m_d;
      k_q <= k_d;
    end
  end

  assign bus.in_ready  = !k_q.valid;
  assign bus.out_valid = m_q.valid;
  assign bus.out_imm   = m_q.imm;
  assign bus.out_fmt   = m_q.fmt;
  assign bus.out_tag   = m_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed-table and back-pressure bench for imm_gen_pipe (XLEN=32 and XLEN=64 side by side).
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  f32;
    logic [2:0]  f64;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
  } exp_t;

  localparam int unsigned NVEC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_tag;

  int checks   = 0;
  int failures = 0;

  vec_t vecs [NVEC];
  exp_t exp_q [$];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.in_instr  = in_instr;
  assign b32.in_tag    = in_tag;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_instr  = in_instr;
  assign b64.in_tag    = in_tag;
  assign b64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          sent;
    int          cyc;
    int          idx;
    int          tagn;
    logic        stalled;
    logic [63:0] s_imm;
    logic [2:0]  s_fmt;
    logic [31:0] s_tag;
    exp_t        e;

    vecs[0]  = '{"addi",   32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1};
    vecs[1]  = '{"sw",     32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2};
    vecs[2]  = '{"lui",    32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4};
    vecs[3]  = '{"jal0",   32'h0000006F, 32'h00000000, 64'h0,                3'd5, 3'd5};
    vecs[4]  = '{"add",    32'h00000033, 32'h00000000, 64'h0,                3'd0, 3'd0};
`ifdef IMM_GEN_ZICSR_EN
    vecs[5]  = '{"csrrwi", 32'h300FD073, 32'h0000001F, 64'h1F,               3'd6, 3'd6};
`else
    vecs[5]  = '{"csrrwi", 32'h300FD073, 32'h00000000, 64'h0,                3'd0, 3'd0};
`endif
    vecs[6]  = '{"addiw",  32'hFFF0009B, 32'h00000000, 64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd1};
    vecs[7]  = '{"beq_m2", 32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd3, 3'd3};
    vecs[8]  = '{"beq_p8", 32'h00000463, 32'h00000008, 64'h8,                3'd3, 3'd3};
    vecs[9]  = '{"jal_m4", 32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd5, 3'd5};
    vecs[10] = '{"auipc",  32'h12345017, 32'h12345000, 64'h12345000,         3'd4, 3'd4};
    vecs[11] = '{"lw",     32'h7FF02083, 32'h000007FF, 64'h7FF,              3'd1, 3'd1};
    vecs[12] = '{"jalr",   32'h00008067, 32'h00000000, 64'h0,                3'd1, 3'd1};
    vecs[13] = '{"ecall",  32'h00000073, 32'h00000000, 64'h0,                3'd0, 3'd0};
    vecs[14] = '{"csrrw",  32'h30001073, 32'h00000000, 64'h0,                3'd0, 3'd0};
    vecs[15] = '{"jal_2k", 32'h001000EF, 32'h00000800, 64'h800,              3'd5, 3'd5};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(b64.out_valid), 64'd0);
    check("rst_in_ready",  64'(b64.in_ready),  64'd1);
    check("rst_in_ready32", 64'(b32.in_ready), 64'd1);
    check("rst_out_imm",   b64.out_imm,        64'd0);
    check("rst_out_fmt",   64'(b64.out_fmt),   64'd0);
    check("rst_out_tag",   64'(b64.out_tag),   64'd0);

    // Streaming table at full throughput
    for (int i = 0; i < int'(NVEC); i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_tag   = 32'(i + 100);
      tick();
      check({vecs[i].name, "_valid"}, 64'(b64.out_valid), 64'd1);
      check({vecs[i].name, "_tag"},   64'(b64.out_tag),   64'(i + 100));
      check({vecs[i].name, "_imm32"}, 64'(b32.out_imm),   64'(vecs[i].imm32));
      check({vecs[i].name, "_fmt32"}, 64'(b32.out_fmt),   64'(vecs[i].f32));
      check({vecs[i].name, "_imm64"}, b64.out_imm,        vecs[i].imm64);
      check({vecs[i].name, "_fmt64"}, 64'(b64.out_fmt),   64'(vecs[i].f64));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid",    64'(b64.out_valid), 64'd0);
    check("drain_hold_imm", b64.out_imm,        vecs[NVEC-1].imm64);

    // Back-pressure: tags 1..4 with out_ready low for three cycles
    out_ready = 1'b0; in_valid = 1'b1; in_instr = vecs[0].instr; in_tag = 32'd1;
    check("bp_ready_t1", 64'(b64.in_ready), 64'd1);
    tick();
    check("bp_valid_t1", 64'(b64.out_valid), 64'd1);
    check("bp_ready_t2", 64'(b64.in_ready),  64'd1);
    in_tag = 32'd2;
    tick();
    check("bp_ready_full", 64'(b64.in_ready), 64'd0);
    check("bp_hold_tag1",  64'(b64.out_tag),  64'd1);
    in_tag = 32'd3;
    tick();
    check("bp_ready_full2", 64'(b64.in_ready), 64'd0);
    check("bp_hold_tag1b",  64'(b64.out_tag),  64'd1);
    out_ready = 1'b1;
    tagn = 3;
    for (int k = 0; k < 4; k++) begin
      logic acc;
      check("bp_order_valid", 64'(b64.out_valid), 64'd1);
      check("bp_order_tag",   64'(b64.out_tag),   64'(k + 1));
      acc = in_valid && b64.in_ready;
      tick();
      if (acc) begin
        if (tagn == 4) in_valid = 1'b0;
        tagn++;
        in_tag = 32'(tagn);
      end
    end
    check("bp_empty", 64'(b64.out_valid), 64'd0);

    // Reset with both M and K occupied
    out_ready = 1'b0; in_valid = 1'b1; in_instr = vecs[2].instr; in_tag = 32'hA1;
    tick();
    in_tag = 32'hA2;
    tick();
    check("mr_full", 64'(b64.in_ready), 64'd0);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("mr_out_valid", 64'(b64.out_valid), 64'd0);
    check("mr_in_ready",  64'(b64.in_ready),  64'd1);
    check("mr_out_imm",   b64.out_imm,        64'd0);
    check("mr_out_fmt",   64'(b64.out_fmt),   64'd0);
    check("mr_out_tag",   64'(b64.out_tag),   64'd0);
    rst = 1'b0; in_valid = 1'b1; in_instr = vecs[2].instr; in_tag = 32'h55;
    tick();
    in_valid = 1'b0;
    check("mr_first_valid", 64'(b64.out_valid), 64'd1);
    check("mr_first_tag",   64'(b64.out_tag),   64'h55);
    check("mr_first_imm",   b64.out_imm,        64'hFFFFFFFF80000000);
    out_ready = 1'b1;
    tick();
    check("mr_drain", 64'(b64.out_valid), 64'd0);

    // Random valid/ready stress against the table expectations
    sent = 0; cyc = 0; stalled = 1'b0;
    s_imm = '0; s_fmt = '0; s_tag = '0;
    while ((sent < 10000 || exp_q.size() != 0 || b64.out_valid) && cyc < 60000) begin
      if (stalled) begin
        check("stall_valid", 64'(b64.out_valid), 64'd1);
        check("stall_imm",   b64.out_imm,        s_imm);
        check("stall_fmt",   64'(b64.out_fmt),   64'(s_fmt));
        check("stall_tag",   64'(b64.out_tag),   64'(s_tag));
      end
      idx       = int'($urandom_range(0, NVEC - 1));
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      in_instr  = vecs[idx].instr;
      in_tag    = 32'(sent);
      out_ready = ($urandom_range(0, 3) != 0);
      if (b64.out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stress_extra_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("stress_tag", 64'(b64.out_tag), 64'(e.tag));
          check("stress_imm", b64.out_imm,      e.imm);
          check("stress_fmt", 64'(b64.out_fmt), 64'(e.fmt));
        end
      end
      if (in_valid && b64.in_ready) begin
        exp_q.push_back('{vecs[idx].imm64, vecs[idx].f64, 32'(sent)});
        sent++;
      end
      stalled = b64.out_valid && !out_ready;
      s_imm = b64.out_imm;
      s_fmt = b64.out_fmt;
      s_tag = b64.out_tag;
      tick();
      cyc++;
    end
    check("stress_done_in_time", 64'(cyc < 60000), 64'd1);
    check("stress_all_sent", 64'(sent), 64'd10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined successor to the combinational immediate generator. Accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes its immediate, sign-extended to XLEN, together with a format code. The result is registered behind a two-entry skid buffer so the decode stage can be back-pressured without a combinational ready path. The block sits between fetch/decode and the register-read stage and forwards an opaque tag (PC, ROB id) alongside each result.

## Interface
- XLEN, 32: output immediate width; legal values 32, 64.
- TAG_W, 32: width of the pass-through tag.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction/tag present.
- in_ready  output  1  block can accept this cycle; registered.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband, returned unmodified.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts this cycle.
- out_imm  output  XLEN  decoded immediate.
- out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- out_tag  output  TAG_W  tag of the result.

## Operation
- Opcode decode on in_instr[6:0]:
  - I for 0010011, 0000011, 1100111, and 0011011 when XLEN=64.
  - S for 0100011.
  - B for 1100011.
  - U for 0110111, 0010111.
  - J for 1101111.
  - Anything else decodes to NONE with imm 0.
- Bit layouts are standard RISC-V. B and J are the LSB-zero offsets. U is instr[31:12] followed by 12 zeros.
- All formats except Z are sign-extended from instr[31] to XLEN. For XLEN=64, U-type bits 63:32 equal instr[31].
- Storage is a main register (M), which drives the outputs, plus a skid register (K). Each holds valid, imm, fmt and tag.
- in_ready = !K.valid.
- Accept occurs on in_valid && in_ready. Fire occurs on out_valid && out_ready.
- On accept, the decoded entry goes to M if M is empty or fires in the same cycle; otherwise it goes to K.
- On fire with K valid, K moves to M and K is cleared. An accept in that same cycle is impossible, because in_ready was 0.
- On fire with K empty and no accept, M is cleared.
- Ordering is strictly FIFO. No entry is dropped or duplicated.

## Timing
- Latency: an accept in cycle N makes out_valid visible in cycle N+1 when the output path is empty.
- Throughput: one result per cycle while out_ready=1.
- in_ready is a pure register output; there is no combinational path from out_ready to in_ready.
- Reset (any cycle, including mid-stream): M.valid=0, K.valid=0, out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_tag=0. Any in-flight entries are discarded.
- When out_valid=0, out_imm, out_fmt and out_tag hold their last values; consumers must ignore them.
- While out_valid=1 and out_ready=0, out_* must stay stable.

## Configuration
- IMM_GEN_ZICSR_EN defined: opcode 1110011 with instr[14]=1 (CSR*I) decodes as Z, with imm = zero-extended instr[19:15] (5-bit uimm). Other SYSTEM encodings decode as NONE.
- IMM_GEN_ZICSR_EN not defined: every 1110011 encoding decodes as NONE with imm 0, and code 6 is never produced.

## Structure
- Shared package: opcode localparams (OP_IMM, LOAD, JALR, OP_IMM_32, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM) and the imm_fmt_t 3-bit enum.
- One sub-module, imm_decode_comb: purely combinational, taking instr and returning imm[XLEN-1:0] and fmt. It is instantiated once on the input side.
- The skid/handshake logic lives in the top module.

## Test plan
- XLEN=32, out_ready=1: 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, out_fmt=1. 0xFE112E23 (sw x1,-4(x2)) -> 0xFFFFFFFC, out_fmt=2.
- XLEN=64: 0x800002B7 (lui x5,0x80000) -> 0xFFFFFFFF80000000, out_fmt=4. 0x0000006F (jal x0,0) -> 0, out_fmt=5. 0x00000033 (add) -> 0, out_fmt=0.
- Back-pressure: in_valid=1 with tags 1,2,3,4 while out_ready=0 for 3 cycles.
  - Tags 1 and 2 are accepted, then in_ready=0.
  - After out_ready=1, out_tag emits 1,2,3,4 in consecutive cycles.
- Reset mid-stream: assert rst with M and K both valid -> next cycle out_valid=0 and in_ready=1. The first post-reset accept appears exactly one cycle later.
- 0x300FD073 (csrrwi x0,mstatus,31):
  - With IMM_GEN_ZICSR_EN: out_imm=0x1F, out_fmt=6.
  - Without it: out_imm=0, out_fmt=0.
- Random valid/ready stress over 10k instructions, checked against a reference model: no loss, no duplication, order preserved, and out_* stable while stalled.
